// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - shared types and constants for the sequential divider
package seq_divider_pkg;
  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;
endpackage

// File: rtl/seq_divider_div_step.sv
// rtl/seq_divider_div_step.sv - one combinational restoring-division iteration
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] dsr,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  always_comb begin
    shifted = {rem_in, bit_in};
    diff    = {1'b0, shifted} - {2'b00, dsr};
    // A non-negative difference is always below the divisor, so both top bits clear means no borrow
    q_bit   = ~|diff[WIDTH+1:WIDTH];
    rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end
endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle radix-2 restoring divider with start/busy/done handshake
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             neg_a, neg_b;
  logic [WIDTH-1:0] step_rem;
  logic             step_bit;

  assign neg_a = signed_op & dividend[WIDTH-1];
  assign neg_b = signed_op & divisor[WIDTH-1];

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .bit_in  (dvd_q[WIDTH-1]),
    .dsr     (dsr_q),
    .rem_out (step_rem),
    .q_bit   (step_bit)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    dvd_d       = dvd_q;
    dsr_d       = dsr_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    busy_d      = busy_q;
    done_d      = done_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
            done_d      = 1'b1;
            state_d     = DONE;
          end else begin
            dvd_d     = neg_a ? -dividend : dividend;
            dsr_d     = neg_b ? -divisor : divisor;
            neg_quo_d = neg_a ^ neg_b;
            neg_rem_d = neg_a;
            rem_d     = '0;
            cnt_d     = CW'(WIDTH - 1);
            busy_d    = 1'b1;
            state_d   = CALC;
          end
        end
      end
      CALC: begin
        // Quotient bits fill the dividend register from the bottom as dividend bits leave the top
        rem_d = step_rem;
        dvd_d = {dvd_q[WIDTH-2:0], step_bit};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = FIX;
      end
      FIX: begin
        quotient_d  = neg_quo_q ? -dvd_q : dvd_q;
        remainder_d = neg_rem_q ? -rem_q : rem_q;
        dbz_d       = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        done_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      dsr_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      dvd_q       <= dvd_d;
      dsr_q       <= dsr_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - randomized self-checking bench for seq_divider
module tb_seq_divider;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        signed_op = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  seq_divider dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_op   (signed_op),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division, truncating toward zero, remainder takes the dividend's sign
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [31:0] eq, output logic [31:0] er, output logic ez);
    longint sa, sb;
    if (b == 0) begin
      eq = 32'hFFFF_FFFF; er = a; ez = 1'b1;
    end else if (!s) begin
      eq = a / b; er = a % b; ez = 1'b0;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      eq = 32'(sa / sb); er = 32'(sa % sb); ez = 1'b0;
    end
  endtask

  // Called at a negedge while the divider is idle; returns at the negedge of the done cycle.
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input int inject);
    logic [31:0] eq, er;
    logic        ez;
    int          cyc, busy_cnt, done_cyc, busy_at_done;
    model(a, b, s, eq, er, ez);
    dividend = a; divisor = b; signed_op = s; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cyc = 1; busy_cnt = 0; done_cyc = 0; busy_at_done = 0;
    while (cyc <= 40 && done_cyc == 0) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cyc = cyc;
        busy_at_done = int'(busy);
        start = 1'b0;
      end else begin
        dividend  = $urandom;
        divisor   = $urandom;
        signed_op = 1'($urandom);
        start     = (cyc == inject);
        @(negedge clk);
        cyc++;
      end
    end
    check({tag, " done_cycle"}, 32'(done_cyc), (b == 0) ? 32'd1 : 32'd34);
    check({tag, " busy_cycles"}, 32'(busy_cnt), (b == 0) ? 32'd0 : 32'd33);
    check({tag, " busy_at_done"}, 32'(busy_at_done), 32'd0);
    check({tag, " quotient"}, quotient, eq);
    check({tag, " remainder"}, remainder, er);
    check({tag, " div_by_zero"}, 32'(div_by_zero), 32'(ez));
  endtask

  function automatic logic [31:0] pick_operand(input bit allow_zero);
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0: v = allow_zero ? 32'd0 : 32'd3;
      1: v = 32'($urandom_range(1, 15));
      2: v = -32'($urandom_range(1, 15));
      3: v = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'hFFFF_FFFF;
      4: v = 32'd1;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    int dones;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset quotient", quotient, 32'd0);
    check("reset remainder", remainder, 32'd0);
    check("reset dbz", 32'(div_by_zero), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_div("u100_7", 32'd100, 32'd7, 1'b0, 0);
    @(negedge clk);
    run_div("s-7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 0);
    @(negedge clk);
    run_div("s7_-2", 32'd7, 32'hFFFF_FFFE, 1'b1, 0);
    @(negedge clk);
    run_div("u5_0", 32'd5, 32'd0, 1'b0, 0);
    @(negedge clk);
    run_div("s-5_0", 32'hFFFF_FFFB, 32'd0, 1'b1, 0);
    @(negedge clk);
    run_div("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    @(negedge clk);
    run_div("u_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 0);
    @(negedge clk);
    run_div("inject", 32'd1000, 32'd9, 1'b0, 5);

    // Start held through DONE must be ignored there and accepted on the following cycle
    dividend = 32'd100; divisor = 32'd7; signed_op = 1'b0; start = 1'b1;
    @(negedge clk);
    check("done_ignores_start busy", 32'(busy), 32'd0);
    check("done_ignores_start done", 32'(done), 32'd0);
    run_div("b2b", 32'd100, 32'd7, 1'b0, 0);
    @(negedge clk);

    // Reset in the middle of CALC
    dividend = 32'd100; divisor = 32'd7; signed_op = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset done", 32'(done), 32'd0);
    check("midreset quotient", quotient, 32'd0);
    check("midreset remainder", remainder, 32'd0);
    check("midreset dbz", 32'(div_by_zero), 32'd0);
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    check("midreset no_activity", 32'(dones), 32'd0);
    run_div("post_reset", 32'd100, 32'd7, 1'b0, 0);

    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      run_div($sformatf("rand%0d", i), pick_operand(1'b0) ^ (($urandom_range(0, 1) != 0) ? $urandom : 32'd0),
              pick_operand(1'b1), 1'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle 32-bit integer divider for the ALU. It provides the inverse of the carry-look-ahead add path: quotient and remainder by repeated trial subtraction.
- Restoring radix-2 algorithm, one quotient bit per clock, with a start/busy/done handshake.
- Sits beside the combinational adder in the ALU datapath. The ALU control stalls on busy.

Parameters:
- WIDTH, 32: operand, quotient and remainder width in bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request a division; sampled only in IDLE
- signed_op  input  1  1 = two's-complement division, 0 = unsigned
- dividend  input  WIDTH  numerator, sampled with start
- divisor  input  WIDTH  denominator, sampled with start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when results become valid
- quotient  output  WIDTH  registered quotient, held until the next accepted start
- remainder  output  WIDTH  registered remainder, held until the next accepted start
- div_by_zero  output  1  registered flag for the last result, held with quotient

Behaviour:
- Reset: rst=1 at a clock edge forces state IDLE. busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, all internal registers 0. This applies in any state, including mid-CALC; the in-flight operation is discarded and no done is produced.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=0: stay in IDLE.
  - start=1, divisor≠0: latch operand magnitudes (absolute values when signed_op=1, raw values otherwise), latch sign flags, clear the partial remainder, load the iteration counter with WIDTH-1, go to CALC.
  - start=1, divisor=0: go to DONE with quotient=all ones, remainder=dividend (unmodified), div_by_zero=1.
- CALC, one iteration per cycle:
  - Shift {partial remainder, dividend register} left by 1.
  - Trial-subtract the divisor magnitude from the shifted remainder (WIDTH+1-bit subtract).
  - No borrow: keep the difference and shift in quotient bit 1. Borrow: restore and shift in 0.
  - Counter decrements; after the iteration with counter=0, go to FIX.
  - Exactly WIDTH CALC cycles.
- FIX:
  - signed_op=1: negate the quotient if the dividend and divisor signs differ; negate the remainder if the dividend was negative. Remainder sign always follows the dividend.
  - Register quotient, remainder and div_by_zero=0, then go to DONE.
- DONE: done=1 for exactly this cycle, then go to IDLE.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: magnitude 2^31 fits unsigned, so quotient=0x80000000 and remainder=0, with no special-casing beyond the natural path.
- Timing, with start accepted at rising edge T:
  - busy=1 from T+1 through T+WIDTH+1 (CALC and FIX).
  - done=1 during cycle T+WIDTH+2, with busy=0 in that cycle.
  - Latency is therefore WIDTH+2 = 34 cycles.
  - Divide-by-zero: done=1 during cycle T+1; busy is never asserted.
- start is ignored when not in IDLE, including during DONE. A new start is first accepted on the cycle after DONE.
- Operands may change after acceptance with no effect on the operation in flight.
- Outputs change only in FIX, or on the IDLE→DONE zero-divisor path. Between operations they hold the last result.

Decomposition:
- Package seq_divider_pkg:
  - state enum: IDLE=2'd0, CALC=2'd1, FIX=2'd2, DONE=2'd3
  - WIDTH default constant
  - counter width localparam, $clog2(WIDTH)
- Sub-module div_step: combinational single restoring iteration.
  - Inputs: partial remainder, next dividend bit, divisor magnitude.
  - Outputs: new partial remainder, quotient bit.
  - Built on the existing subtract path.
- The FSM, counter and sign fix-up stay in seq_divider.

Test Plan:
- Unsigned 100 / 7, start at T → done at T+34; quotient=14, remainder=2, div_by_zero=0; busy high exactly 33 cycles.
- Signed -7 / 2 (0xFFFFFFF9 / 2) → quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). Signed 7 / -2 → quotient=-3, remainder=1.
- Divide-by-zero: 5 / 0 unsigned → done at T+1, quotient=0xFFFFFFFF, remainder=5, div_by_zero=1, busy never high. Repeat with signed_op=1 and dividend=-5: remainder=0xFFFFFFFB.
- Signed 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0. Unsigned 0xFFFFFFFF / 1 → quotient=0xFFFFFFFF, remainder=0.
- Pulse start with new operands at T+5 during CALC → ignored; the original result is delivered at T+34 unchanged. Back-to-back: start high on the cycle after DONE is accepted.
- Assert rst at T+10 mid-CALC → next cycle all outputs 0 and state IDLE; no done pulse; a fresh 100 / 7 afterwards completes correctly.
